mult_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of `register_file`: it takes `read_data1` (rs) and `read_data2` (rt) as operands for MULT/MULTU/DIV/DIVU, and exposes HI/LO to the writeback mux for MFHI/MFLO. It is a one-bit-per-cycle shift-add multiplier and restoring divider, with a start/busy/done handshake that the control path uses to stall.

---
 rtl/mult_div_if.sv | 27 ++
 rtl/mult_div_unit.sv | 148 ++++++++++++++
 tb/tb_mult_div_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Handshake and data bundle between the control path and the multiply/divide unit.
// The control path is the master; the unit is the slave.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, mt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, mt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-cycle multiply (shift-add) and divide (restoring) unit
// with architectural HI/LO registers and MTHI/MTLO write ports.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus,
    output logic [1:0] state_o
);
    // Handshake: start is a request taken only in IDLE (no queueing); busy marks
    // the WIDTH iteration cycles; done is a one-cycle pulse with HI/LO updated.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q;
    logic               neg_a_q, neg_b_q, div_zero_q;
    logic [WIDTH-1:0]   opnd_q, rs_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic             accept;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    assign accept = (state_q == S_IDLE) && bus.start;
    assign rs_neg = bus.op[0] & bus.rs_data[WIDTH-1];
    assign rt_neg = bus.op[0] & bus.rt_data[WIDTH-1];
    assign rs_mag = rs_neg ? -bus.rs_data : bus.rs_data;
    assign rt_mag = rt_neg ? -bus.rt_data : bus.rt_data;

    // Multiply: accumulator holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: accumulator holds {partial remainder, dividend bits / quotient bits}.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign q_bit     = ~div_diff[WIDTH+1];
    assign rem_new   = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_next  = {rem_new, acc_q[WIDTH-2:0], q_bit};

    assign acc_d = is_div_q ? div_next : mul_next;

    // Sign fix-up applied to the last iteration's value on the RUN->DONE edge.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_d : acc_d;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    assign rem_fix  = neg_a_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                res_hi = rs_q;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_RUN) begin
            if (bus.hi_we) hi_d = bus.mt_data;
            if (bus.lo_we) lo_d = bus.mt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand latch; no reset needed since it is only read in RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_q   <= bus.op[1];
            rs_q       <= bus.rs_data;
            div_zero_q <= (bus.rt_data == '0);
            neg_a_q    <= rs_neg;
            neg_b_q    <= rt_neg;
            if (bus.op[1]) begin
                opnd_q <= rt_mag;
                acc_q  <= {{WIDTH{1'b0}}, rs_mag};
            end else begin
                opnd_q <= rs_mag;
                acc_q  <= {{WIDTH{1'b0}}, rt_mag};
            end
        end else if (state_q == S_RUN) begin
            acc_q <= acc_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign state_o  = state_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;
    int         checks;
    int         failures;

    mult_div_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint     sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    hi = a;
                    lo = '1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: begin
                if (b == 0) begin
                    hi = a;
                    lo = '1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = '0;
                end else begin
                    lo = 32'(sa / sb);
                    hi = 32'(sa % sb);
                end
            end
        endcase
    endfunction

    // Launch one op and follow it to completion, checking timing and result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb, input bit mt_with_start,
                          input logic [31:0] mt_val);
        logic [31:0] exp_hi, exp_lo, hold_hi, hold_lo;
        int busy_cnt, done_at;
        bit stable;
        model(op, a, b, exp_hi, exp_lo);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        if (mt_with_start) begin
            bus.lo_we   = 1'b1;
            bus.mt_data = mt_val;
        end
        @(posedge clk);
        #1;
        hold_hi  = bus.hi;
        hold_lo  = bus.lo;
        busy_cnt = bus.busy ? 1 : 0;
        done_at  = -1;
        stable   = 1'b1;
        if (mt_with_start) chk({tag, "_mt_with_start"}, {32'd0, bus.lo}, {32'd0, mt_val});
        for (int n = 1; n <= W + 8 && done_at < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start   = 1'b0;
                bus.lo_we   = 1'b0;
                bus.rs_data = $urandom;
                bus.rt_data = $urandom;
            end
            if (disturb && n == 5) begin
                bus.start   = 1'b1;
                bus.op      = 2'($urandom_range(0, 3));
                bus.rs_data = $urandom;
                bus.rt_data = $urandom;
            end
            if (disturb && n == 6) bus.start = 1'b0;
            if (disturb && n == 8) begin
                bus.hi_we   = 1'b1;
                bus.mt_data = 32'h1234;
            end
            if (disturb && n == 9) bus.hi_we = 1'b0;
            @(posedge clk);
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.done) done_at = n;
            else if (bus.hi !== hold_hi || bus.lo !== hold_lo) stable = 1'b0;
        end
        chk({tag, "_latency"}, 64'(done_at), 64'(W));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
        chk({tag, "_hilo_stable_in_run"}, {63'd0, stable}, 64'd1);
        chk({tag, "_result"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse_end"}, {62'd0, bus.done, bus.busy}, 64'd0);
        chk({tag, "_result_hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [31:0] ra, rb, prev_hi;
        logic [1:0]  rop;
        bit          seen_done;
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.mt_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("multu_full", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
        chk("multu_full_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, '0);
        run_op("mult_m1xm1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
        run_op("div_m7by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0);
        chk("div_m7by2_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_100by7", 2'b10, 32'd100, 32'd7, 1'b0, 1'b0, '0);
        run_op("div_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
        run_op("divu_by0", 2'b10, 32'd100, 32'd0, 1'b0, 1'b0, '0);
        run_op("div_m5by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, '0);

        run_op("handshake_6x7", 2'b00, 32'd6, 32'd7, 1'b1, 1'b0, '0);
        chk("handshake_const", {bus.hi, bus.lo}, 64'd42);
        prev_hi = bus.hi;
        @(negedge clk);
        bus.lo_we   = 1'b1;
        bus.mt_data = 32'hABCD;
        @(posedge clk);
        #1;
        chk("mtlo_idle", {bus.hi, bus.lo}, {prev_hi, 32'h0000_ABCD});
        @(negedge clk);
        bus.lo_we = 1'b0;

        run_op("start_with_mtlo", 2'b01, 32'h0001_2345, 32'hFFFF_0F00, 1'b0, 1'b1, 32'h5A5A_0001);

        // Abort a DIVU with reset and confirm it never completes.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = 2'b10;
        bus.rs_data = $urandom;
        bus.rt_data = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mid_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_mid_done", {63'd0, bus.done}, 64'd0);
        chk("reset_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset     = 1'b0;
        seen_done = 1'b0;
        for (int n = 0; n < W + 8; n++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        chk("reset_mid_no_done", {63'd0, seen_done}, 64'd0);
        run_op("after_reset", 2'b10, 32'd1000, 32'd33, 1'b0, 1'b0, '0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0, 1'b0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
